// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline sequencing controller for the 5-stage 19-bit MIPS core. It handles
// the hazards that forwarding cannot cover: load-use stalls, taken-branch
// flushes, data-memory waits (with a timeout to a sticky error state) and an
// externally requested drain/halt. It also keeps saturating statistics.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   if_id_instr           instruction held in IF/ID
//   id_ex_instr           instruction held in ID/EX
//   ex_branch_taken       branch in EX resolved taken
//   mem_busy              data memory not ready this cycle
//   halt_req              level request to drain and halt
//   pc_write/pc_sel_branch  PC load enable / load branch target
//   if_id_write/if_id_flush IF/ID load enable / load NOP
//   id_ex_flush           ID/EX loads a bubble
//   back_write            EX/MEM and MEM/WB load enable
//   halt_ack              pipeline empty and halted
//   mem_timeout_err       sticky memory timeout flag
//   state                 current FSM state (RUN=0 .. ERROR=4)
//   stall_cnt, flush_cnt  saturating statistics counters
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [18:0]      if_id_instr,
  input  logic [18:0]      id_ex_instr,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             back_write,
  output logic             halt_ack,
  output logic             mem_timeout_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);
  localparam logic [DRN_W-1:0] DRN_LIM = DRN_W'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_MEMWAIT = 3'd1,
    S_DRAIN   = 3'd2,
    S_HALTED  = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t           cur, nxt;
  logic [TMO_W-1:0] tmo, tmo_nxt;
  logic [DRN_W-1:0] drn, drn_nxt;
  logic             err;
  logic             stall_inc, flush_inc;

  // Instruction decode
  logic       f_alu, f_imm, f_lw, f_sw, d_lw;
  logic [2:0] d_dst;
  logic       load_use;
  logic       unused_bits;

  assign f_alu = ~if_id_instr[18];
  assign f_imm = if_id_instr[17];
  assign f_lw  = (if_id_instr[18:14] == 5'b10000);
  assign f_sw  = (if_id_instr[18:14] == 5'b10001);
  assign d_lw  = (id_ex_instr[18:14] == 5'b10000);
  assign d_dst = id_ex_instr[13:11];

  // SW's data register (B) is deliberately not checked: the forwarding unit
  // resolves a LW->SW data dependency memory-to-memory.
  assign load_use = d_lw && (d_dst != 3'd0) &&
                    (((f_alu || f_lw || f_sw) && (if_id_instr[10:8] == d_dst)) ||
                     (f_alu && !f_imm && (if_id_instr[7:5] == d_dst)));

  assign unused_bits = ^{if_id_instr[13:11], if_id_instr[4:0], id_ex_instr[10:0]};

  always_comb begin
    nxt           = cur;
    tmo_nxt       = '0;
    drn_nxt       = drn;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    back_write    = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    halt_ack      = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (cur)
      // MEMWAIT without mem_busy decodes exactly like RUN, so a branch held
      // off by the freeze is taken on the release cycle.
      S_RUN, S_MEMWAIT: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          back_write  = 1'b0;
          stall_inc   = 1'b1;
          tmo_nxt     = tmo + 1'b1;
          nxt         = (tmo_nxt == TMO_LIM) ? S_ERROR : S_MEMWAIT;
        end else begin
          nxt = S_RUN;
          if (ex_branch_taken) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            flush_inc     = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end
          if (halt_req) begin
            nxt     = S_DRAIN;
            drn_nxt = '0;
          end
        end
      end

      S_DRAIN: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          back_write  = 1'b0;
          stall_inc   = 1'b1;
          tmo_nxt     = tmo + 1'b1;
          nxt         = (tmo_nxt == TMO_LIM) ? S_ERROR : S_DRAIN;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (ex_branch_taken) begin
            pc_write      = 1'b1;
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            flush_inc     = 1'b1;
          end
          if (!halt_req) begin
            nxt = S_RUN;
          end else begin
            drn_nxt = drn + 1'b1;
            if (drn_nxt == DRN_LIM) nxt = S_HALTED;
          end
        end
      end

      S_HALTED: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        halt_ack    = halt_req;
        if (!halt_req) nxt = S_RUN;
      end

      S_ERROR: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        back_write  = 1'b0;
      end

      default: begin
        nxt = S_RUN;
      end
    endcase

    // Reset overrides the combinational outputs immediately, not at the edge.
    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      back_write    = 1'b0;
      pc_sel_branch = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      halt_ack      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_RUN;
      tmo       <= '0;
      drn       <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cur <= nxt;
      tmo <= tmo_nxt;
      drn <= drn_nxt;
      if (nxt == S_ERROR) err <= 1'b1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign state           = cur;
  assign mem_timeout_err = err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by randomized
// traffic. The driver computes each cycle's expected response from a
// behavioural model and queues it; an independent monitor pops and compares
// on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W        = 4;
  localparam int MEM_TIMEOUT  = 64;
  localparam int DRAIN_CYCLES = 3;
  localparam int CMAX         = (1 << CNT_W) - 1;

  localparam logic [18:0] NOP    = 19'b00000_000_000_000_00000;
  localparam logic [18:0] LW_R2  = 19'b10000_010_001_000_00000;
  localparam logic [18:0] ADD_R3 = 19'b00000_011_010_100_00000;
  localparam logic [18:0] ADDI_B = 19'b01000_011_100_010_00000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [18:0]      if_id_instr = '0;
  logic [18:0]      id_ex_instr = '0;
  logic             ex_branch_taken = 1'b0;
  logic             mem_busy = 1'b0;
  logic             halt_req = 1'b0;
  logic             pc_write, pc_sel_branch, if_id_write, if_id_flush;
  logic             id_ex_flush, back_write, halt_ack, mem_timeout_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_id_instr    (if_id_instr),
    .id_ex_instr    (id_ex_instr),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .halt_req       (halt_req),
    .pc_write       (pc_write),
    .pc_sel_branch  (pc_sel_branch),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .back_write     (back_write),
    .halt_ack       (halt_ack),
    .mem_timeout_err(mem_timeout_err),
    .state          (state),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  typedef struct packed {
    logic             pc_write;
    logic             pc_sel_branch;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             back_write;
    logic             halt_ack;
    logic             err;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
  } resp_t;

  resp_t expq[$];
  int    checks = 0;
  int    failures = 0;

  // Reference model: mode numbers follow the state encoding of the block
  // (0 run, 1 memory wait, 2 drain, 3 halted, 4 error).
  int m_mode, m_busy_run, m_drained, m_stalls, m_flushes;
  bit m_err;

  function automatic bit reads_reg(input logic [18:0] f, input logic [2:0] d);
    bit alu, imm, lw, sw;
    alu = (f[18] == 1'b0);
    imm = (f[17] == 1'b1);
    lw  = (f[18:14] == 5'b10000);
    sw  = (f[18:14] == 5'b10001);
    return ((alu || lw || sw) && (f[10:8] == d)) || (alu && !imm && (f[7:5] == d));
  endfunction

  function automatic bit hazard(input logic [18:0] fi, input logic [18:0] di);
    logic [2:0] dst;
    dst = di[13:11];
    return (di[18:14] == 5'b10000) && (dst != 3'd0) && reads_reg(fi, dst);
  endfunction

  task automatic model_cycle(input bit rst, input logic [18:0] fi, input logic [18:0] di,
                             input bit br, input bit busy, input bit halt, output resp_t e);
    int  nmode;
    bit  stall, flush;
    e = '0;
    if (!rst) begin
      e.if_id_flush = 1'b1;
      e.id_ex_flush = 1'b1;
      m_mode = 0; m_busy_run = 0; m_drained = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
      return;
    end
    e.state     = 3'(m_mode);
    e.stall_cnt = CNT_W'(m_stalls);
    e.flush_cnt = CNT_W'(m_flushes);
    e.err       = m_err;
    nmode = m_mode;
    stall = 0;
    flush = 0;
    if (m_mode == 4) begin
      // error: everything held off until reset
    end else if (m_mode == 3) begin
      e.back_write  = 1'b1;
      e.id_ex_flush = 1'b1;
      e.halt_ack    = halt;
      if (!halt) nmode = 0;
    end else if (busy) begin
      // full freeze while memory is busy, in run, wait or drain
      stall = 1;
      m_busy_run++;
      if (m_busy_run >= MEM_TIMEOUT) nmode = 4;
      else nmode = (m_mode == 2) ? 2 : 1;
    end else begin
      m_busy_run = 0;
      if (m_mode == 2) begin
        e.back_write  = 1'b1;
        e.id_ex_flush = 1'b1;
        if (br) begin
          e.pc_write      = 1'b1;
          e.pc_sel_branch = 1'b1;
          e.if_id_flush   = 1'b1;
          flush = 1;
        end
        if (!halt) nmode = 0;
        else begin
          m_drained++;
          nmode = (m_drained == DRAIN_CYCLES) ? 3 : 2;
        end
      end else begin
        e.pc_write    = 1'b1;
        e.if_id_write = 1'b1;
        e.back_write  = 1'b1;
        if (br) begin
          e.pc_sel_branch = 1'b1;
          e.if_id_flush   = 1'b1;
          e.id_ex_flush   = 1'b1;
          flush = 1;
        end else if (hazard(fi, di)) begin
          e.pc_write    = 1'b0;
          e.if_id_write = 1'b0;
          e.id_ex_flush = 1'b1;
          stall = 1;
        end
        nmode = halt ? 2 : 0;
        if (halt) m_drained = 0;
      end
    end
    if (nmode == 4) m_err = 1;
    if (stall && m_stalls < CMAX) m_stalls++;
    if (flush && m_flushes < CMAX) m_flushes++;
    m_mode = nmode;
  endtask

  task automatic step(input bit rst, input logic [18:0] fi, input logic [18:0] di,
                      input bit br, input bit busy, input bit halt);
    resp_t e;
    @(posedge clk);
    #1;
    rst_n           = rst;
    if_id_instr     = fi;
    id_ex_instr     = di;
    ex_branch_taken = br;
    mem_busy        = busy;
    halt_req        = halt;
    model_cycle(rst, fi, di, br, busy, halt, e);
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pc_write",        32'(pc_write),        32'(e.pc_write));
        chk("pc_sel_branch",   32'(pc_sel_branch),   32'(e.pc_sel_branch));
        chk("if_id_write",     32'(if_id_write),     32'(e.if_id_write));
        chk("if_id_flush",     32'(if_id_flush),     32'(e.if_id_flush));
        chk("id_ex_flush",     32'(id_ex_flush),     32'(e.id_ex_flush));
        chk("back_write",      32'(back_write),      32'(e.back_write));
        chk("halt_ack",        32'(halt_ack),        32'(e.halt_ack));
        chk("mem_timeout_err", 32'(mem_timeout_err), 32'(e.err));
        chk("state",           32'(state),           32'(e.state));
        chk("stall_cnt",       32'(stall_cnt),       32'(e.stall_cnt));
        chk("flush_cnt",       32'(flush_cnt),       32'(e.flush_cnt));
      end
    end
  end

  function automatic logic [18:0] rand_instr();
    logic [18:0] x;
    x = 19'($urandom);
    case ($urandom_range(0, 4))
      0:       x[18:17] = 2'b00;
      1:       x[18:17] = 2'b01;
      2:       x[18:14] = 5'b10000;
      3:       x[18:14] = 5'b10001;
      default: x[18:16] = 3'b101;
    endcase
    x[13:11] = 3'($urandom_range(0, 3));
    x[10:8]  = 3'($urandom_range(0, 3));
    x[7:5]   = 3'($urandom_range(0, 3));
    return x;
  endfunction

  // Driver
  initial begin
    int  busy_left;
    bit  halt, rst;
    step(0, NOP, NOP, 0, 0, 0);
    step(0, NOP, NOP, 0, 0, 0);
    step(1, NOP, NOP, 0, 0, 0);

    // load-use, then the bubble reaches ID/EX
    step(1, ADD_R3, LW_R2, 0, 0, 0);
    step(1, ADD_R3, NOP, 0, 0, 0);
    // immediate form: B matches but is not a source
    step(1, ADDI_B, LW_R2, 0, 0, 0);
    step(1, NOP, NOP, 0, 0, 0);

    // branch alone, then branch with a load-use present
    step(1, NOP, NOP, 1, 0, 0);
    step(1, ADD_R3, LW_R2, 1, 0, 0);
    step(1, NOP, NOP, 0, 0, 0);

    // 5 busy cycles with a pending branch, applied on cycle 6
    step(0, NOP, NOP, 0, 0, 0);
    step(1, NOP, NOP, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, NOP, NOP, 1, 1, 0);
    step(1, NOP, NOP, 1, 0, 0);
    step(1, NOP, NOP, 0, 0, 0);

    // halt: drain, halted, then resume with the held IF/ID instruction
    for (int i = 0; i < 6; i++) step(1, ADD_R3, NOP, 0, 0, 1);
    step(1, ADD_R3, NOP, 0, 0, 0);
    step(1, ADD_R3, NOP, 0, 0, 0);

    // drain interrupted by memory wait and a branch, and halt dropped mid-drain
    step(1, NOP, NOP, 0, 0, 1);
    step(1, NOP, NOP, 0, 1, 1);
    step(1, NOP, NOP, 0, 1, 1);
    step(1, NOP, NOP, 1, 0, 1);
    step(1, NOP, NOP, 0, 0, 0);
    step(1, NOP, NOP, 0, 0, 0);

    // one cycle short of the timeout
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(1, NOP, NOP, 0, 1, 0);
    step(1, NOP, NOP, 0, 0, 0);

    // timeout, error held, cleared by reset
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1, NOP, NOP, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, ADD_R3, LW_R2, 1, 0, 0);
    step(0, NOP, NOP, 0, 0, 0);
    step(1, NOP, NOP, 0, 0, 0);

    // reset asserted mid-wait
    for (int i = 0; i < 3; i++) step(1, NOP, NOP, 0, 1, 0);
    step(0, NOP, NOP, 0, 1, 0);
    step(1, NOP, NOP, 0, 0, 0);

    // saturation of both counters
    for (int i = 0; i < 20; i++) step(1, ADD_R3, LW_R2, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, NOP, NOP, 1, 0, 0);
    step(0, NOP, NOP, 0, 0, 0);

    // randomized traffic
    busy_left = 0;
    halt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy_left == 0) begin
        if ($urandom_range(0, 299) == 0) busy_left = MEM_TIMEOUT + 2;
        else if ($urandom_range(0, 14) == 0) busy_left = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 24) == 0) halt = !halt;
      rst = ($urandom_range(0, 399) != 0);
      step(rst, rand_instr(), rand_instr(), ($urandom_range(0, 5) == 0),
           (busy_left > 0), halt);
      if (busy_left > 0) busy_left--;
    end
    step(1, NOP, NOP, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0 pending", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage 19-bit MIPS core. It sits beside the forwarding unit and drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers the cases forwarding cannot resolve:
- load-use stalls
- taken-branch flushes
- multi-cycle data-memory waits, with timeout
- externally requested pipeline drain and halt

It also keeps saturating stall and flush statistics.

Parameters:
- CNT_W, 16, width of the statistics counters.
- MEM_TIMEOUT, 64, consecutive mem_busy cycles before timeout error; must be 2 or more.
- DRAIN_CYCLES, 3, bubble cycles needed to retire the ID/EX, EX/MEM and MEM/WB contents.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_id_instr  in  19  instruction in IF/ID.
- id_ex_instr  in  19  instruction in ID/EX.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_busy  in  1  data memory not ready this cycle.
- halt_req  in  1  level request to drain and halt.
- pc_write  out  1  PC load enable.
- pc_sel_branch  out  1  PC loads branch target.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_flush  out  1  ID/EX loads bubble.
- back_write  out  1  EX/MEM and MEM/WB load enable.
- halt_ack  out  1  pipeline empty and halted.
- mem_timeout_err  out  1  sticky timeout flag.
- state  out  3  current FSM state.
- stall_cnt  out  CNT_W  load-use plus memory-wait stall cycles.
- flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:

Instruction decode:
- Fields: opcode [18:14], dst [13:11], A [10:8], B [7:5].
- ALU: bit18=0. Immediate: bit17=1. LW: 10000. SW: 10001. Branch: [18:16]=101.

Load-use hazard (combinational), true when all of the following hold:
- id_ex is LW, and its dst is not 0.
- AND one of:
  - if_id A equals id_ex dst, for ALU, LW or SW in IF/ID; or
  - if_id B equals id_ex dst, for non-immediate ALU in IF/ID.
- SW data register matching a LW dst is not a hazard; the forwarding unit handles it memory-to-memory.

FSM states:
- RUN=0, MEMWAIT=1, DRAIN=2, HALTED=3, ERROR=4.
- Reset state is RUN.

Outputs are combinational from state and inputs. Default is pc_write=if_id_write=back_write=1 and all others 0.

Reset:
- While rst_n=0: pc_write, if_id_write and back_write are 0; if_id_flush and id_ex_flush are 1.
- Counters, err, halt_ack and the internal timeout/drain counters are all 0.
- Reset mid-operation aborts any state immediately, including ERROR.

RUN, evaluated in priority order:
1. mem_busy: all enables 0, no flushes, stall_cnt++, next state MEMWAIT, tmo=1.
2. ex_branch_taken: pc_sel_branch=1, if_id_flush=1, id_ex_flush=1, flush_cnt++.
3. load-use: pc_write=0, if_id_write=0, id_ex_flush=1, stall_cnt++.
   - One-cycle stall only; the next cycle sees the bubble in ID/EX.
4. Then, if halt_req and not mem_busy: next state DRAIN, drain counter=0.
   - The branch or stall action above still applies in that cycle.

MEMWAIT:
- Full freeze as in RUN step 1; stall_cnt++ each cycle.
- mem_busy=0: return to RUN with normal RUN decoding that cycle. A branch deferred by the freeze is applied now.
- tmo reaching MEM_TIMEOUT while still busy: next state ERROR.

DRAIN:
- pc_write=0, if_id_write=0, id_ex_flush=1. The IF/ID instruction is held, not lost.
- ex_branch_taken overrides: pc_write=1, pc_sel_branch=1, if_id_flush=1, flush_cnt++.
- mem_busy: full freeze; drain counter and tmo behave as in MEMWAIT; timeout goes to ERROR.
- Counter reaching DRAIN_CYCLES: next state HALTED.
- halt_req dropping mid-drain: return to RUN next cycle.

HALTED:
- Same freeze as DRAIN; halt_ack=1.
- halt_req=0: next state RUN, and halt_ack drops that same cycle.

ERROR:
- All enables 0, flushes 0.
- mem_timeout_err=1, sticky until reset.

Counters:
- Saturate at all-ones; no wrap.
- Increment on the cycle the condition is asserted.

Test Plan:
1. Load-use:
   - Stimulus: id_ex = LW r2 (10000_010_001_000_00000), if_id = ADD r3,r2,r4 (00000_011_010_100_00000).
   - Required: exactly one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, then stall_cnt=1.
   - Same with ADDI r3,r4,imm where B=010 (10000 on id_ex, if_id bit17=1): no stall.
2. Branch:
   - Stimulus: ex_branch_taken=1 for 1 cycle.
   - Required: pc_sel_branch=1, if_id_flush=id_ex_flush=1, flush_cnt=1.
   - With load-use present at the same time: no pc_write=0 stall.
3. Memory wait:
   - Stimulus: mem_busy=1 for 5 cycles together with a branch taken.
   - Required: 5 cycles of full freeze with state=1 and stall_cnt=5; the branch flush occurs on cycle 6.
4. Timeout:
   - Stimulus: mem_busy held for 64 cycles.
   - Required: state=4 and mem_timeout_err=1, held after mem_busy drops; cleared only by rst_n pulse.
5. Halt:
   - Stimulus: halt_req=1.
   - Required: state=2 for 3 cycles with id_ex_flush=1, then state=3 with halt_ack=1.
   - Dropping halt_req: state=0 the next cycle and the IF/ID instruction resumes.
6. Reset and saturation:
   - Stimulus: assert rst_n=0 asynchronously mid-MEMWAIT.
   - Required: outputs go to reset values immediately.
   - With CNT_W=4: 20 stalls leave stall_cnt=15.
